bit_serial_adder: RTL and testbench

//   Multi-cycle WIDTH-bit adder that drives a one-bit half-adder datapath serially, LSB first.
//   The datapath is two half adders plus an OR gate, forming a full adder.
//   A registered carry links successive bits.

---
 rtl/bit_serial_adder.sv | 144 ++++++++++++++
 tb/tb_bit_serial_adder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_adder.sv
// -----------------------------------------------------------------------------
// bit_serial_adder
//
// Purpose:
//   Multi-cycle WIDTH-bit adder. One full-adder slice (two half adders plus an
//   OR gate) is reused once per bit, LSB first. A registered carry links the
//   successive bits. One addition costs WIDTH+2 cycles from the accepting edge
//   to the next accepting edge.
//
// Handshake:
//   start is sampled only while idle (busy=0). On the accepting edge a, b and
//   cin are captured, and busy rises. After WIDTH RUN cycles, sum/cout are
//   updated on the edge that enters DONE, and done is high for exactly that
//   one cycle. Any start seen while busy=1 is dropped, not queued.
//
// Ports:
//   clk    in   1      system clock, rising edge
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      request an addition (sampled only in IDLE)
//   a      in   WIDTH  operand A, captured on the accepting edge
//   b      in   WIDTH  operand B, captured on the accepting edge
//   cin    in   1      carry-in, captured on the accepting edge
//   busy   out  1      high in RUN and DONE
//   done   out  1      one-cycle pulse: sum/cout hold a new result
//   sum    out  WIDTH  result of the last completed addition
//   cout   out  1      carry-out of the last completed addition
// -----------------------------------------------------------------------------
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Sized to hold WIDTH, so the count never wraps inside one operation.
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift_a;
    logic [WIDTH-1:0]   r_shift_b;
    logic [WIDTH-1:0]   r_acc;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic               w_s1;
    logic               w_c1;
    logic               w_s;
    logic               w_c2;
    logic               w_carry_next;
    logic [WIDTH-1:0]   w_acc_next;
    logic               w_last_bit;

    // One-bit datapath: half adder on the operand bits, half adder with the
    // running carry, OR of the two partial carries.
    assign w_s1         = r_shift_a[0] ^ r_shift_b[0];
    assign w_c1         = r_shift_a[0] & r_shift_b[0];
    assign w_s          = w_s1 ^ r_carry;
    assign w_c2         = w_s1 & r_carry;
    assign w_carry_next = w_c1 | w_c2;

    // Sum bit enters at the MSB, so after WIDTH shifts bit 0 holds the LSB.
    // Taking the top WIDTH bits of {s, acc} also covers WIDTH=1 (result = s).
    assign w_acc_next = WIDTH'({w_s, r_acc} >> 1);

    assign w_last_bit = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift_a <= '0;
            r_shift_b <= '0;
            r_acc     <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_shift_a <= a;
                        r_shift_b <= b;
                        r_carry   <= cin;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_shift_a <= r_shift_a >> 1;
                    r_shift_b <= r_shift_b >> 1;
                    r_acc     <= w_acc_next;
                    r_carry   <= w_carry_next;
                    r_cnt     <= r_cnt + CNT_W'(1);
                    if (w_last_bit) begin
                        // Result is published from the combinational next
                        // values so it lands on the same edge as DONE.
                        r_sum   <= w_acc_next;
                        r_cout  <= w_carry_next;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_bit_serial_adder.sv
module tb_bit_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // WIDTH=8 instance
    logic       s8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       c8 = 1'b0;
    logic       bz8, d8, co8;
    logic [7:0] sm8;

    // WIDTH=1 instance
    logic       s1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       c1 = 1'b0;
    logic       bz1, d1, co1;
    logic [0:0] sm1;

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .cin(c8),
        .busy(bz8), .done(d8), .sum(sm8), .cout(co8)
    );

    bit_serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1), .cin(c1),
        .busy(bz1), .done(d1), .sum(sm1), .cout(co1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge with the WIDTH=8 DUT idle. Returns at a
    // negedge with the DUT idle again. inject_at >= 0 pulses start with other
    // operands while the operation is in flight.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input int inject_at, input string tag);
        logic [8:0] exp;
        int lat;
        exp = 9'(a) + 9'(b) + 9'(c);
        a8 = a; b8 = b; c8 = c; s8 = 1'b1;
        @(posedge clk); #1;
        s8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom_range(0, 1));
        lat = 0;
        while (lat < 30) begin
            @(posedge clk); #1;
            s8 = 1'b0;
            lat++;
            @(negedge clk);
            if (d8) break;
            if (lat == inject_at) begin
                chk({tag, "_busy_inj"}, 32'(bz8), 32'd1);
                s8 = 1'b1; a8 = 8'h01; b8 = 8'h01; c8 = 1'b0;
            end
        end
        chk({tag, "_lat"},  32'(lat), 32'd8);
        chk({tag, "_busy"}, 32'(bz8), 32'd1);
        chk({tag, "_sum"},  32'({co8, sm8}), 32'(exp));
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done_w"}, 32'(d8), 32'd0);
        chk({tag, "_idle"},   32'(bz8), 32'd0);
    endtask

    task automatic op1(input logic a, input logic b, input logic c, input string tag);
        logic [1:0] exp;
        int lat;
        exp = 2'(a) + 2'(b) + 2'(c);
        a1 = a; b1 = b; c1 = c; s1 = 1'b1;
        @(posedge clk); #1;
        s1 = 1'b0;
        a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
        lat = 0;
        while (lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (d1) break;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd1);
        chk({tag, "_sum"}, 32'({co1, sm1}), 32'(exp));
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done_w"}, 32'(d1), 32'd0);
        chk({tag, "_idle"},   32'(bz1), 32'd0);
    endtask

    initial begin
        logic [8:0] e;
        // Reset
        repeat (2) @(negedge clk);
        chk("rst_busy8", 32'(bz8), 32'd0);
        chk("rst_done8", 32'(d8),  32'd0);
        chk("rst_sum8",  32'({co8, sm8}), 32'd0);
        chk("rst_busy1", 32'(bz1), 32'd0);
        chk("rst_sum1",  32'({co1, sm1}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed operations
        op8(8'h35, 8'h4A, 1'b0, -1, "basic");
        op8(8'hFF, 8'h01, 1'b0, -1, "wrap");
        op8(8'hFF, 8'hFF, 1'b1, -1, "max");
        op8(8'h00, 8'h00, 1'b1, -1, "cin_only");

        // start pulsed while busy is dropped
        op8(8'h10, 8'h20, 1'b0, 2, "ignore");
        @(negedge clk);
        chk("ignore_no_restart", 32'(bz8), 32'd0);

        // Reset in the middle of RUN discards the operation
        a8 = 8'hAA; b8 = 8'h11; c8 = 1'b0; s8 = 1'b1;
        @(posedge clk); #1;
        s8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(bz8), 32'd0);
        chk("midrst_done", 32'(d8),  32'd0);
        chk("midrst_sum",  32'({co8, sm8}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        op8(8'h0F, 8'h01, 1'b0, -1, "after_rst");

        // start held high: accepts every WIDTH+2 = 10 cycles
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom_range(0, 1));
        s8 = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            if (cyc % 10 == 0) begin
                exp_q.push_back(9'(a8) + 9'(b8) + 9'(c8));
                a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (cyc % 10 == 8) begin
                chk("hold_done", 32'(d8), 32'd1);
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
                chk("hold_sum", 32'({co8, sm8}), 32'(e));
            end else begin
                chk("hold_nodone", 32'(d8), 32'd0);
            end
            if (cyc == 39) s8 = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("hold_stopped", 32'(bz8), 32'd0);

        // Random operations on both widths
        for (int i = 0; i < 1000; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), -1, "rnd8");
        for (int i = 0; i < 1000; i++)
            op1(1'($urandom), 1'($urandom), 1'($urandom_range(0, 1)), "rnd1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard so the run always ends
    initial begin
        #2000000;
        bad++;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
